issue_scoreboard: RTL and testbench

- Issue stage between decode and the three execution pipes: X (ALU/shift), M (multiply) and L (load/store).
- Holds one decoded instruction and reads its operands from the register file.
- Detects RAW/WAW register hazards and writeback-port conflicts using per-register countdown counters and a writeback-slot reservation vector.
- Drives the registered is_x_* style issue bundle; a bubble is signalled by functionalunit=0.

---
 rtl/issue_scoreboard_pkg.sv | 35 +++
 rtl/issue_regcounters.sv | 51 +++++
 rtl/issue_scoreboard.sv | 193 +++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue stage: unit encodings, ctrl field
// layout and the default pipe latencies the hazard logic is sized from.
package issue_scoreboard_pkg;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_X    = 2'd1,
    FU_M    = 2'd2,
    FU_L    = 2'd3
  } fu_e;

  // ctrl = {selalushift, selimregb, aluop[2:0], unsig, shiftop[1:0], shiftamt[4:0], writeov}
  localparam int CTRL_W            = 14;
  localparam int CTRL_WRITEOV      = 0;
  localparam int CTRL_SHIFTAMT_LSB = 1;
  localparam int CTRL_SHIFTOP_LSB  = 6;
  localparam int CTRL_UNSIG        = 8;
  localparam int CTRL_ALUOP_LSB    = 9;
  localparam int CTRL_SELIMREGB    = 12;
  localparam int CTRL_SELALUSHIFT  = 13;

  // Result latency of each pipe, measured from the issue edge to the
  // first cycle the register file returns the new value.
  localparam int DEF_LAT_X = 5;
  localparam int DEF_LAT_M = 7;
  localparam int DEF_LAT_L = 6;
  localparam int DEF_CNTW  = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/issue_regcounters.sv
// Per-register countdown counters: a nonzero count means the register's
// pending result is not yet readable. r0 never has a pending result.
module issue_regcounters
  import issue_scoreboard_pkg::*;
#(
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      rs_addr_i,
  input  logic [4:0]      rt_addr_i,
  input  logic [4:0]      wd_addr_i,
  input  logic            set_en_i,
  input  logic [4:0]      set_addr_i,
  input  logic [CNTW-1:0] set_val_i,
  output logic            rs_busy_o,
  output logic            rt_busy_o,
  output logic            wd_busy_o
);

  logic [CNTW-1:0] cnt_q [32];
  logic [CNTW-1:0] cnt_d [32];

  // Load on issue beats the per-cycle decrement; entry 0 stays zero
  always_comb begin
    cnt_d[0] = '0;
    for (int i = 1; i < 32; i++) begin
      if (set_en_i && (set_addr_i == 5'(i))) begin
        cnt_d[i] = set_val_i;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rs_busy_o = (rs_addr_i != 5'd0) && (cnt_q[rs_addr_i] != '0);
  assign rt_busy_o = (rt_addr_i != 5'd0) && (cnt_q[rt_addr_i] != '0);
  assign wd_busy_o = (wd_addr_i != 5'd0) && (cnt_q[wd_addr_i] != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage: holds one decoded instruction, reads its operands and
// releases it to X/M/L only when no RAW/WAW hazard or writeback-port
// collision is pending. Bubbles go out as functionalunit = 0.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int LAT_X = DEF_LAT_X,
  parameter int LAT_M = DEF_LAT_M,
  parameter int LAT_L = DEF_LAT_L,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_is_valid,
  input  logic [1:0]        id_is_functionalunit,
  input  logic [CTRL_W-1:0] id_is_ctrl,
  input  logic [31:0]       id_is_imedext,
  input  logic [4:0]        id_is_rs,
  input  logic [4:0]        id_is_rt,
  input  logic              id_is_usert,
  input  logic [4:0]        id_is_regdest,
  input  logic              id_is_writereg,
  output logic              is_id_stall,
  output logic [4:0]        is_rf_rsaddr,
  output logic [4:0]        is_rf_rtaddr,
  input  logic [31:0]       rf_is_rsdata,
  input  logic [31:0]       rf_is_rtdata,
  output logic [1:0]        is_x_functionalunit,
  output logic [CTRL_W-1:0] is_x_ctrl,
  output logic [31:0]       is_x_rega,
  output logic [31:0]       is_x_regb,
  output logic [31:0]       is_x_imedext,
  output logic [4:0]        is_x_regdest,
  output logic              is_x_writereg
);

  // One bit per future writeback cycle; bit 0 is the nearest
  localparam int SLOTW = max3(LAT_X, LAT_M, LAT_L);

  logic              buf_valid_q;
  fu_e               buf_fu_q;
  logic [CTRL_W-1:0] buf_ctrl_q;
  logic [31:0]       buf_imm_q;
  logic [4:0]        buf_rs_q;
  logic [4:0]        buf_rt_q;
  logic              buf_usert_q;
  logic [4:0]        buf_rd_q;
  logic              buf_wr_q;

  logic [SLOTW-1:0]  slot_q;
  logic [SLOTW-1:0]  slot_d;

  logic [1:0]        x_fu_q;
  logic [CTRL_W-1:0] x_ctrl_q;
  logic [31:0]       x_rega_q;
  logic [31:0]       x_regb_q;
  logic [31:0]       x_imm_q;
  logic [4:0]        x_rd_q;
  logic              x_wr_q;

  logic [CNTW-1:0]   lat_cnt;
  logic [SLOTW-1:0]  lat_slot;
  logic              rs_nz;
  logic              rt_nz;
  logic              wd_nz;
  logic              slot_busy;
  logic              hazard;
  logic              issue;
  logic              cnt_set_en;

  // Latency of the buffered unit, as a counter load value and as the
  // one-hot slot it would claim
  always_comb begin
    lat_cnt  = '0;
    lat_slot = '0;
    case (buf_fu_q)
      FU_X: begin
        lat_cnt  = CNTW'(LAT_X);
        lat_slot = SLOTW'(1) << (LAT_X - 1);
      end
      FU_M: begin
        lat_cnt  = CNTW'(LAT_M);
        lat_slot = SLOTW'(1) << (LAT_M - 1);
      end
      FU_L: begin
        lat_cnt  = CNTW'(LAT_L);
        lat_slot = SLOTW'(1) << (LAT_L - 1);
      end
      default: begin
        lat_cnt  = '0;
        lat_slot = '0;
      end
    endcase
  end

  issue_regcounters #(
    .CNTW(CNTW)
  ) u_regcounters (
    .clock     (clock),
    .reset     (reset),
    .rs_addr_i (buf_rs_q),
    .rt_addr_i (buf_rt_q),
    .wd_addr_i (buf_rd_q),
    .set_en_i  (cnt_set_en),
    .set_addr_i(buf_rd_q),
    .set_val_i (lat_cnt),
    .rs_busy_o (rs_nz),
    .rt_busy_o (rt_nz),
    .wd_busy_o (wd_nz)
  );

  assign slot_busy  = buf_wr_q & (|(slot_q & lat_slot));
  assign hazard     = buf_valid_q &
                      (rs_nz | (buf_usert_q & rt_nz) | (buf_wr_q & wd_nz) | slot_busy);
  assign issue      = buf_valid_q & ~hazard;
  assign cnt_set_en = issue & buf_wr_q & (buf_rd_q != 5'd0);

  // Reservations age by one slot per cycle; a new claim lands after the shift
  assign slot_d = (slot_q >> 1) | ((issue & buf_wr_q) ? lat_slot : '0);

  assign is_id_stall  = hazard;
  assign is_rf_rsaddr = buf_rs_q;
  assign is_rf_rtaddr = buf_rt_q;

  // Instruction buffer: takes the decode bundle whenever it is not stalling
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_fu_q    <= FU_NONE;
      buf_ctrl_q  <= '0;
      buf_imm_q   <= '0;
      buf_rs_q    <= '0;
      buf_rt_q    <= '0;
      buf_usert_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_wr_q    <= 1'b0;
    end else if (!hazard) begin
      buf_valid_q <= id_is_valid & (id_is_functionalunit != 2'd0);
      buf_fu_q    <= fu_e'(id_is_functionalunit);
      buf_ctrl_q  <= id_is_ctrl;
      buf_imm_q   <= id_is_imedext;
      buf_rs_q    <= id_is_rs;
      buf_rt_q    <= id_is_rt;
      buf_usert_q <= id_is_usert;
      buf_rd_q    <= id_is_regdest;
      buf_wr_q    <= id_is_writereg;
    end
  end

  // Writeback-slot reservation register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  // Issue bundle: the buffered instruction with its operands, or an all-zero bubble
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_fu_q   <= '0;
      x_ctrl_q <= '0;
      x_rega_q <= '0;
      x_regb_q <= '0;
      x_imm_q  <= '0;
      x_rd_q   <= '0;
      x_wr_q   <= 1'b0;
    end else if (issue) begin
      x_fu_q   <= buf_fu_q;
      x_ctrl_q <= buf_ctrl_q;
      x_rega_q <= rf_is_rsdata;
      x_regb_q <= rf_is_rtdata;
      x_imm_q  <= buf_imm_q;
      x_rd_q   <= buf_rd_q;
      x_wr_q   <= buf_wr_q;
    end else begin
      x_fu_q   <= '0;
      x_ctrl_q <= '0;
      x_rega_q <= '0;
      x_regb_q <= '0;
      x_imm_q  <= '0;
      x_rd_q   <= '0;
      x_wr_q   <= 1'b0;
    end
  end

  assign is_x_functionalunit = x_fu_q;
  assign is_x_ctrl           = x_ctrl_q;
  assign is_x_rega           = x_rega_q;
  assign is_x_regb           = x_regb_q;
  assign is_x_imedext        = x_imm_q;
  assign is_x_regdest        = x_rd_q;
  assign is_x_writereg       = x_wr_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed hazard sequences plus a random
// stream, checked against a timestamp-based model of register readiness
// and writeback reservations.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        id_is_valid = 1'b0;
  logic [1:0]  id_is_functionalunit = '0;
  logic [13:0] id_is_ctrl = '0;
  logic [31:0] id_is_imedext = '0;
  logic [4:0]  id_is_rs = '0;
  logic [4:0]  id_is_rt = '0;
  logic        id_is_usert = 1'b0;
  logic [4:0]  id_is_regdest = '0;
  logic        id_is_writereg = 1'b0;
  logic        is_id_stall;
  logic [4:0]  is_rf_rsaddr;
  logic [4:0]  is_rf_rtaddr;
  logic [31:0] rf_is_rsdata;
  logic [31:0] rf_is_rtdata;
  logic [1:0]  is_x_functionalunit;
  logic [13:0] is_x_ctrl;
  logic [31:0] is_x_rega;
  logic [31:0] is_x_regb;
  logic [31:0] is_x_imedext;
  logic [4:0]  is_x_regdest;
  logic        is_x_writereg;

  typedef struct packed {
    logic [1:0]  fu;
    logic [13:0] ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wr;
  } bundle_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  fu;
    logic [13:0] ctrl;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        usert;
    logic [4:0]  rd;
    logic        wr;
  } ins_t;

  int      vectors = 0;
  int      miscompares = 0;
  bit      mon_en = 1'b0;
  int      rf_seed = 0;
  bundle_t exp_q[$];
  ins_t    dq[$];

  // Reference model: ready[r] is the edge index from which r is readable,
  // wb_due holds the edge index at which each claimed writeback slot expires
  ins_t    mb;
  int      ready[32];
  int      wb_due[$];
  int      now = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] rf_fn(input logic [4:0] a, input int s);
    return {a, 27'(s * 7 + 13 * int'(a) + 1)};
  endfunction

  assign rf_is_rsdata = rf_fn(is_rf_rsaddr, rf_seed);
  assign rf_is_rtdata = rf_fn(is_rf_rtaddr, rf_seed);

  issue_scoreboard dut (
    .clock               (clock),
    .reset               (reset),
    .id_is_valid         (id_is_valid),
    .id_is_functionalunit(id_is_functionalunit),
    .id_is_ctrl          (id_is_ctrl),
    .id_is_imedext       (id_is_imedext),
    .id_is_rs            (id_is_rs),
    .id_is_rt            (id_is_rt),
    .id_is_usert         (id_is_usert),
    .id_is_regdest       (id_is_regdest),
    .id_is_writereg      (id_is_writereg),
    .is_id_stall         (is_id_stall),
    .is_rf_rsaddr        (is_rf_rsaddr),
    .is_rf_rtaddr        (is_rf_rtaddr),
    .rf_is_rsdata        (rf_is_rsdata),
    .rf_is_rtdata        (rf_is_rtdata),
    .is_x_functionalunit (is_x_functionalunit),
    .is_x_ctrl           (is_x_ctrl),
    .is_x_rega           (is_x_rega),
    .is_x_regb           (is_x_regb),
    .is_x_imedext        (is_x_imedext),
    .is_x_regdest        (is_x_regdest),
    .is_x_writereg       (is_x_writereg)
  );

  function automatic int lat_of(input logic [1:0] fu);
    case (fu)
      2'd1:    return 5;
      2'd2:    return 7;
      2'd3:    return 6;
      default: return 0;
    endcase
  endfunction

  function automatic ins_t mk(input logic [1:0] fu, input logic [4:0] rd, input logic [4:0] rs,
                              input logic [4:0] rt, input logic wr, input logic usert);
    ins_t n;
    n.valid = 1'b1; n.fu = fu; n.rd = rd; n.rs = rs; n.rt = rt; n.wr = wr; n.usert = usert;
    n.ctrl = 14'($urandom); n.imm = $urandom;
    return n;
  endfunction

  function automatic ins_t rand_ins();
    ins_t n;
    n = mk(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    n.valid = ($urandom_range(0, 9) != 0);
    return n;
  endfunction

  function automatic bit reg_busy(input logic [4:0] r);
    return (r != 5'd0) && (ready[r] > now);
  endfunction

  function automatic bit model_hazard();
    bit slot_hit;
    int l;
    if (!mb.valid) return 1'b0;
    l = lat_of(mb.fu);
    slot_hit = 1'b0;
    foreach (wb_due[k]) if (wb_due[k] - now == l - 1) slot_hit = 1'b1;
    return reg_busy(mb.rs) || (mb.usert && reg_busy(mb.rt)) ||
           (mb.wr && reg_busy(mb.rd)) || (mb.wr && slot_hit);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    wb_due.delete();
    mb = '0;
    exp_q.delete();
  endtask

  // One cycle of stimulus, called on the falling edge: check stall, predict
  // the bundle for the coming edge, advance the model, drive decode.
  task automatic step();
    bit      hz;
    bundle_t x;
    ins_t    n;
    int      l;
    hz = model_hazard();
    vectors++;
    if (is_id_stall !== hz) begin
      miscompares++;
      $display("FAIL stall edge=%0d got=%0b want=%0b", now, is_id_stall, hz);
    end
    rf_seed = $urandom;
    x = '0;
    if (mb.valid && !hz) begin
      l = lat_of(mb.fu);
      x = '{fu: mb.fu, ctrl: mb.ctrl, a: rf_fn(mb.rs, rf_seed), b: rf_fn(mb.rt, rf_seed),
            imm: mb.imm, rd: mb.rd, wr: mb.wr};
      if (mb.wr) begin
        if (mb.rd != 5'd0) ready[mb.rd] = now + 1 + l;
        wb_due.push_back(now + l);
      end
    end
    exp_q.push_back(x);
    if (!hz) begin
      n = (dq.size() != 0) ? dq.pop_front() : rand_ins();
      id_is_valid = n.valid; id_is_functionalunit = n.fu; id_is_ctrl = n.ctrl;
      id_is_imedext = n.imm; id_is_rs = n.rs; id_is_rt = n.rt; id_is_usert = n.usert;
      id_is_regdest = n.rd; id_is_writereg = n.wr;
      mb = n;
      mb.valid = n.valid && (n.fu != 2'd0);
    end
    now++;
    for (int k = wb_due.size() - 1; k >= 0; k--) if (wb_due[k] < now) wb_due.delete(k);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    bundle_t act;
    act = '{fu: is_x_functionalunit, ctrl: is_x_ctrl, a: is_x_rega, b: is_x_regb,
            imm: is_x_imedext, rd: is_x_regdest, wr: is_x_writereg};
    vectors++;
    if (act !== '0) begin
      miscompares++;
      $display("FAIL %s_bundle got=%h want=0", tag, act);
    end
    vectors++;
    if (is_id_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_stall got=%0b want=0", tag, is_id_stall);
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    mon_en = 1'b1;
    step();
  endtask

  // Monitor: compares the issue bundle just after every rising edge
  always @(posedge clock) begin
    bundle_t act;
    bundle_t want;
    #2;
    if (mon_en) begin
      act = '{fu: is_x_functionalunit, ctrl: is_x_ctrl, a: is_x_rega, b: is_x_regb,
              imm: is_x_imedext, rd: is_x_regdest, wr: is_x_writereg};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bundle_underflow got=%h want=<none>", act);
      end else begin
        want = exp_q.pop_front();
        if (act !== want) begin
          miscompares++;
          $display("FAIL bundle fu got=%0d want=%0d rd got=%0d want=%0d wr got=%0b want=%0b full got=%h want=%h",
                   act.fu, want.fu, act.rd, want.rd, act.wr, want.wr, act, want);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_outputs("por");

    // RAW, independent X stream, M->X slot conflict, WAW, r0, writereg/usert = 0
    dq.push_back(mk(2'd1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd6, 5'd5, 5'd3, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd1, 5'd10, 5'd11, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd2, 5'd12, 5'd13, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd3, 5'd14, 5'd15, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd4, 5'd16, 5'd17, 1'b1, 1'b1));
    dq.push_back(mk(2'd2, 5'd7, 5'd18, 5'd19, 1'b1, 1'b1));
    dq.push_back('0);
    dq.push_back(mk(2'd1, 5'd8, 5'd20, 5'd21, 1'b1, 1'b1));
    dq.push_back(mk(2'd3, 5'd9, 5'd22, 5'd23, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd9, 5'd24, 5'd25, 1'b1, 1'b1));
    dq.push_back(mk(2'd3, 5'd0, 5'd26, 5'd27, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd11, 5'd28, 5'd29, 1'b0, 1'b1));
    dq.push_back(mk(2'd1, 5'd30, 5'd11, 5'd11, 1'b1, 1'b1));
    dq.push_back(mk(2'd2, 5'd12, 5'd28, 5'd29, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd31, 5'd0, 5'd12, 1'b0, 1'b0));
    release_reset();
    run(60);
    run(300);

    // Reset in the middle of a pending RAW hazard on r5
    dq.push_back(mk(2'd1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1));
    dq.push_back(mk(2'd1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1));
    run(4);
    @(posedge clock);
    #3;
    reset = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("midrst_hold");
    dq.push_back(mk(2'd1, 5'd7, 5'd5, 5'd5, 1'b1, 1'b1));
    dq.push_back(mk(2'd2, 5'd5, 5'd6, 5'd9, 1'b1, 1'b1));
    release_reset();
    run(200);

    @(negedge clock);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
